// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared constants and types for the Monte Carlo path sequencer.
//   DAY    : number of exercise days (power of two, >= 2)
//   N      : paths per day (power of two)
//   W      : price width for paths, strike and result
//   ADDR_W : path store address width, {day, idx}
//   RS_W   : width of the resend counter (counts up to 2*DAY-1)
// ---------------------------------------------------------------------------
package mc_pkg;

   localparam int DAY    = 8;
   localparam int N      = 256;
   localparam int W      = 12;

   localparam int DAY_W  = $clog2(DAY);
   localparam int IDX_W  = $clog2(N);
   localparam int ADDR_W = DAY_W + IDX_W;
   localparam int RS_W   = $clog2(2 * DAY);

   localparam logic [DAY_W-1:0] LAST_DAY = DAY_W'(DAY - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   // Resend count at which the final-day replay has been issued.
   localparam logic [RS_W-1:0]  RS_LAST  = RS_W'(2 * DAY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_STREAM,
      ST_WAIT_RESULT
   } state_e;

   // Path store address: day in the upper bits, path index in the lower bits.
   function automatic logic [ADDR_W-1:0] path_addr(input logic [DAY_W-1:0] day,
                                                   input logic [IDX_W-1:0] idx);
      return {day, idx};
   endfunction

endpackage

// File: rtl/mc_path_ram.sv
// ---------------------------------------------------------------------------
// mc_path_ram
// DAY*N x W path store. One write port, one synchronous read port with a
// single cycle of latency. A read that hits the address being written in the
// same cycle returns the new data (write-first).
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address {day, idx}
//   wr_data_i  : write data
//   rd_addr_i  : read address {day, idx}, sampled every cycle
//   rd_data_o  : read data, valid the cycle after the address
// ---------------------------------------------------------------------------
module mc_path_ram
   import mc_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [W-1:0]      wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [W-1:0]      rd_data_o
);

   logic [W-1:0] mem_q [DAY*N];
   logic [W-1:0] rd_data_q;

   // NOTE: storage arrays carry no reset; their contents are undefined after
   // reset and clearing them would turn a RAM into thousands of flops.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
         rd_data_q <= wr_data_i;
      end else begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mc_path_sequencer.sv
// ---------------------------------------------------------------------------
// mc_path_sequencer
// Owns the simulated-path store and replays day streams to the Monte Carlo
// pricing core in backward-induction order: the last day first, each day
// streamed twice (initial pass plus a replay on an odd resend), stepping one
// day earlier on every even resend. Returns the core result to the host with
// a one-cycle done pulse.
//   clk, rst_n   : clock, asynchronous active-low reset
//   ld_en/ld_day/ld_idx/ld_data : host path write, honoured while not busy
//   cfg_k        : strike, captured on an accepted go
//   go           : start request, accepted while not busy
//   busy         : run in progress (through the done cycle)
//   done, price  : result pulse and held result
//   core_start   : one-cycle start to the core
//   core_path    : path sample stream to the core
//   core_k       : captured strike
//   core_resend  : core asks for a day stream restart
//   core_valid, core_price : core result
// ---------------------------------------------------------------------------
module mc_path_sequencer
   import mc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_en,
   input  logic [DAY_W-1:0] ld_day,
   input  logic [IDX_W-1:0] ld_idx,
   input  logic [W-1:0]     ld_data,
   input  logic [W-1:0]     cfg_k,
   input  logic             go,
   output logic             busy,
   output logic             done,
   output logic [W-1:0]     price,
   output logic             core_start,
   output logic [W-1:0]     core_path,
   output logic [W-1:0]     core_k,
   input  logic             core_resend,
   input  logic             core_valid,
   input  logic [W-1:0]     core_price
);

   state_e            state_q, state_d;
   logic [DAY_W-1:0]  day_q, day_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [RS_W-1:0]   rs_cnt_q, rs_cnt_d;
   logic [W-1:0]      k_q, k_d;
   logic [W-1:0]      price_q, price_d;
   logic              done_q, done_d;

   logic [W-1:0]      head_q [DAY];

   logic              busy_w;
   logic              ld_ok;
   logic              go_ok;
   logic [DAY_W-1:0]  tgt_day;
   logic [IDX_W-1:0]  next_idx;
   logic [DAY_W-1:0]  rd_day;
   logic [IDX_W-1:0]  rd_idx;
   logic              use_head;
   logic              start_w;
   logic [W-1:0]      rd_data;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;

   // Busy stays high through the done cycle so a go or load that arrives
   // together with the result pulse is ignored.
   assign busy_w = (state_q != ST_IDLE) || done_q;
   assign ld_ok  = ld_en && !busy_w;
   assign go_ok  = go && !busy_w;

   // An odd resend count (before increment) means the current day has already
   // been replayed, so this resend steps to the previous day.
   assign tgt_day  = rs_cnt_q[0] ? (day_q - 1'b1) : day_q;
   assign next_idx = (idx_q == LAST_IDX) ? LAST_IDX : (idx_q + 1'b1);

   // -----------------------------------------------------------------------
   // Path store and head register file
   // -----------------------------------------------------------------------
   assign wr_addr = path_addr(ld_day, ld_idx);
   assign rd_addr = path_addr(rd_day, rd_idx);

   mc_path_ram u_ram (
      .clk       (clk),
      .wr_en_i   (ld_ok),
      .wr_addr_i (wr_addr),
      .wr_data_i (ld_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   // Element 0 of every day is mirrored here so a resend can present it in
   // the same cycle, hiding the RAM read latency.
   always_ff @(posedge clk) begin
      if (ld_ok && (ld_idx == '0)) begin
         head_q[ld_day] <= ld_data;
      end
   end

   // -----------------------------------------------------------------------
   // Sequencing FSM: next state and outputs
   // -----------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can infer a latch.
      state_d  = state_q;
      day_d    = day_q;
      idx_d    = idx_q;
      rs_cnt_d = rs_cnt_q;
      k_d      = k_q;
      price_d  = price_q;
      done_d   = 1'b0;
      start_w  = 1'b0;
      use_head = 1'b0;
      rd_day   = day_q;
      rd_idx   = idx_q;

      case (state_q)
         ST_IDLE: begin
            if (go_ok) begin
               k_d      = cfg_k;
               day_d    = LAST_DAY;
               rs_cnt_d = '0;
               price_d  = '0;
               state_d  = ST_LAUNCH;
            end
         end

         ST_LAUNCH: begin
            start_w = 1'b1;
            rd_day  = LAST_DAY;
            rd_idx  = '0;
            idx_d   = '0;
            state_d = ST_STREAM;
         end

         ST_STREAM: begin
            rd_idx = next_idx;
            idx_d  = next_idx;
            if (core_resend && (rs_cnt_q != RS_LAST)) begin
               // Element 0 comes from the head file now; the RAM fetches
               // element 1 for the next cycle.
               use_head = 1'b1;
               day_d    = tgt_day;
               rd_day   = tgt_day;
               rd_idx   = IDX_W'(1);
               idx_d    = IDX_W'(1);
               rs_cnt_d = rs_cnt_q + 1'b1;
            end else if ((rs_cnt_q == RS_LAST) && core_valid) begin
               // Result arrived during the final replay: finish directly.
               price_d = core_price;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if ((rs_cnt_q == RS_LAST) && (idx_q == LAST_IDX)) begin
               state_d = ST_WAIT_RESULT;
            end
         end

         ST_WAIT_RESULT: begin
            if (core_valid) begin
               price_d = core_price;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         day_q    <= '0;
         idx_q    <= '0;
         rs_cnt_q <= '0;
         k_q      <= '0;
         price_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         day_q    <= day_d;
         idx_q    <= idx_d;
         rs_cnt_q <= rs_cnt_d;
         k_q      <= k_d;
         price_q  <= price_d;
         done_q   <= done_d;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   // The sample bus is forced to zero outside the streaming states so stale
   // RAM data never reaches the core after reset or between runs.
   always_comb begin
      core_path = '0;
      if ((state_q == ST_STREAM) || (state_q == ST_WAIT_RESULT)) begin
         core_path = use_head ? head_q[tgt_day] : rd_data;
      end
   end

   assign busy       = busy_w;
   assign done       = done_q;
   assign price      = price_q;
   assign core_start = start_w;
   assign core_k     = k_q;

endmodule
